// File: rtl/div_32.sv
// div_32: signed 32-bit restoring divider, one quotient bit per clock.
// Quotient truncates toward zero; divide-by-zero raises data_exception.
module div_32 (
  input  logic        clock,
  input  logic        reset,
  input  logic        ctrl_DIV,
  input  logic [31:0] data_operandA,
  input  logic [31:0] data_operandB,
  output logic [31:0] data_result,
  output logic        data_exception,
  output logic        data_resultRDY
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_BUSY,
    S_DONE
  } state_t;

  state_t      state_q, state_d;
  logic [4:0]  cnt_q, cnt_d;
  logic [31:0] rem_q, rem_d;
  logic [31:0] quo_q, quo_d;
  logic [31:0] dvs_q, dvs_d;
  logic        sign_q, sign_d;
  logic [31:0] res_q, res_d;
  logic        exc_q, exc_d;
  logic        rdy_q, rdy_d;

  logic [31:0] abs_a;
  logic [31:0] abs_b;
  logic [32:0] shifted;
  logic [32:0] diff;

  // Operand magnitudes; 0x80000000 maps to unsigned 2^31.
  always_comb begin
    abs_a = data_operandA[31] ? (~data_operandA + 32'd1)
                              : data_operandA;
    abs_b = data_operandB[31] ? (~data_operandB + 32'd1)
                              : data_operandB;
  end

  // One restoring step: shift {rem,quo} left, trial-subtract divisor.
  always_comb begin
    shifted = {rem_q, quo_q[31]};
    diff    = shifted - {1'b0, dvs_q};
  end

  // Next-state and datapath; a start strobe wins in every state.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    rem_d   = rem_q;
    quo_d   = quo_q;
    dvs_d   = dvs_q;
    sign_d  = sign_q;
    res_d   = res_q;
    exc_d   = exc_q;
    rdy_d   = 1'b0;
    if (ctrl_DIV) begin
      state_d = S_BUSY;
      cnt_d   = 5'd0;
      rem_d   = 32'd0;
      quo_d   = abs_a;
      dvs_d   = abs_b;
      sign_d  = data_operandA[31] ^ data_operandB[31];
    end else begin
      unique case (state_q)
        S_IDLE: begin
        end
        S_BUSY: begin
          if (diff[32]) begin
            rem_d = shifted[31:0];
            quo_d = {quo_q[30:0], 1'b0};
          end else begin
            rem_d = diff[31:0];
            quo_d = {quo_q[30:0], 1'b1};
          end
          cnt_d = cnt_q + 5'd1;
          if (cnt_q == 5'd31) begin
            state_d = S_DONE;
          end
        end
        S_DONE: begin
          rdy_d   = 1'b1;
          state_d = S_IDLE;
          if (dvs_q == 32'd0) begin
            res_d = 32'd0;
            exc_d = 1'b1;
          end else begin
            res_d = sign_q ? (~quo_q + 32'd1) : quo_q;
            exc_d = 1'b0;
          end
        end
        default: begin
          state_d = S_IDLE;
        end
      endcase
    end
  end

  // State and datapath registers with asynchronous clear.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q <= S_IDLE;
      cnt_q   <= 5'd0;
      rem_q   <= 32'd0;
      quo_q   <= 32'd0;
      dvs_q   <= 32'd0;
      sign_q  <= 1'b0;
      res_q   <= 32'd0;
      exc_q   <= 1'b0;
      rdy_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      rem_q   <= rem_d;
      quo_q   <= quo_d;
      dvs_q   <= dvs_d;
      sign_q  <= sign_d;
      res_q   <= res_d;
      exc_q   <= exc_d;
      rdy_q   <= rdy_d;
    end
  end

  assign data_result    = res_q;
  assign data_exception = exc_q;
  assign data_resultRDY = rdy_q;

endmodule
